// File: rtl/seg7_scan_to_bin.sv
// Recovers hex nibbles from a time-multiplexed 7-segment bus after a stability window.
// Define SEG7_ACTIVE_LOW_EN for common-anode panels (inputs inverted after synchronization).
module seg7_scan_to_bin #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  upd_pulse,
  output logic                  bad_pat,
  output logic                  err_multi
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURED} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYC);

  logic [6:0]          r_seg_s1, r_seg_s2;
  logic [DIGITS-1:0]   r_dig_s1, r_dig_s2;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_dig;
  logic                w_zero, w_onehot, w_multi;

  state_t              r_state, w_state_nxt;
  logic [DIGITS-1:0]   r_strobe, w_strobe_nxt;
  logic [6:0]          r_pat, w_pat_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_prev_multi;
  logic                w_capture, w_err;
  logic [4:0]          w_dec;

  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_valid;
  logic                r_upd, r_bad, r_err;

  // NOTE: every clocked register uses <= so all flops see pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_dig_s1 <= '0;
      r_dig_s2 <= '0;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= dig_en;
      r_dig_s2 <= r_dig_s1;
    end
  end

`ifdef SEG7_ACTIVE_LOW_EN
  assign w_seg = ~r_seg_s2;
  assign w_dig = ~r_dig_s2;
`else
  assign w_seg = r_seg_s2;
  assign w_dig = r_dig_s2;
`endif

  assign w_zero   = (w_dig == '0);
  assign w_onehot = !w_zero && ((w_dig & (w_dig - DIGITS'(1))) == '0);
  assign w_multi  = !w_zero && !w_onehot;

  // Returns {known, nibble}; blank and unknown patterns both report known=0.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F: return 5'h10;
      7'h06: return 5'h11;
      7'h5B: return 5'h12;
      7'h4F: return 5'h13;
      7'h66: return 5'h14;
      7'h6D: return 5'h15;
      7'h7D: return 5'h16;
      7'h07: return 5'h17;
      7'h7F: return 5'h18;
      7'h6F: return 5'h19;
      7'h77: return 5'h1A;
      7'h7C: return 5'h1B;
      7'h39: return 5'h1C;
      7'h5E: return 5'h1D;
      7'h79: return 5'h1E;
      7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign w_dec = decode(w_seg);

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_strobe_nxt = r_strobe;
    w_pat_nxt    = r_pat;
    w_cnt_nxt    = r_cnt;
    w_capture    = 1'b0;
    w_err        = 1'b0;
    if (r_state == ST_IDLE || w_dig != r_strobe || w_seg != r_pat) begin
      if (w_onehot) begin
        w_strobe_nxt = w_dig;
        w_pat_nxt    = w_seg;
        w_cnt_nxt    = 4'd1;
        if (STABLE == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_CAPTURED;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end else begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        // Flag only the first multi-hot sample of a run, not every cycle it persists.
        w_err       = w_multi && !r_prev_multi;
      end
    end else if (r_state == ST_SETTLE) begin
      if (r_cnt < STABLE) w_cnt_nxt = r_cnt + 4'd1;
      if (w_cnt_nxt == STABLE) begin
        w_capture   = 1'b1;
        w_state_nxt = ST_CAPTURED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_strobe     <= '0;
      r_pat        <= '0;
      r_cnt        <= '0;
      r_prev_multi <= 1'b0;
      r_value      <= '0;
      r_valid      <= '0;
      r_upd        <= 1'b0;
      r_bad        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_strobe     <= w_strobe_nxt;
      r_pat        <= w_pat_nxt;
      r_cnt        <= w_cnt_nxt;
      r_prev_multi <= w_multi;
      r_upd        <= w_capture;
      r_bad        <= w_capture && !w_dec[4] && (w_seg != 7'h00);
      r_err        <= w_err;
      // Blank or unknown keeps the old nibble and only drops the valid flag.
      for (int k = 0; k < DIGITS; k++) begin
        if (w_capture && w_dig[k]) begin
          if (w_dec[4]) begin
            r_value[4*k +: 4] <= w_dec[3:0];
            r_valid[k]        <= 1'b1;
          end else begin
            r_valid[k]        <= 1'b0;
          end
        end
      end
    end
  end

  assign value_out   = r_value;
  assign digit_valid = r_valid;
  assign upd_pulse   = r_upd;
  assign bad_pat     = r_bad;
  assign err_multi   = r_err;

endmodule

// File: tb/tb_seg7_scan_to_bin.sv
// Self-checking bench for seg7_scan_to_bin: directed scenarios plus randomized scan traffic
// compared every cycle against a run-length reference model of the decoder.
module tb_seg7_scan_to_bin;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_en = '0;
  logic [15:0] value_out;
  logic [3:0]  digit_valid;
  logic        upd_pulse, bad_pat, err_multi;

  seg7_scan_to_bin #(.DIGITS(DIGITS), .STABLE_CYC(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .value_out   (value_out),
    .digit_valid (digit_valid),
    .upd_pulse   (upd_pulse),
    .bad_pat     (bad_pat),
    .err_multi   (err_multi)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: raw-input delay line and run length of identical samples.
  logic [10:0] pipe1, pipe2, m_last;
  logic        m_have, m_prev_multi;
  int          m_run;
  logic [15:0] exp_value;
  logic [3:0]  exp_valid;
  logic        exp_upd, exp_bad, exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe1 = '0; pipe2 = '0; m_last = '0;
    m_have = 1'b0; m_prev_multi = 1'b0; m_run = 0;
    exp_value = '0; exp_valid = '0;
    exp_upd = 1'b0; exp_bad = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] d, input logic [6:0] s);
    int   ones, k;
    logic found;
    logic [3:0] nib;
    exp_upd = 1'b0; exp_bad = 1'b0; exp_err = 1'b0;
    ones = $countones(d);
    if (ones > 1 && !m_prev_multi) exp_err = 1'b1;
    m_prev_multi = (ones > 1);
    if (m_have && {d, s} == m_last) begin
      if (m_run <= STABLE) m_run++;
    end else begin
      m_run = 1;
    end
    m_last = {d, s};
    m_have = 1'b1;
    if (ones == 1 && m_run == STABLE) begin
      k = 0;
      for (int i = 0; i < DIGITS; i++) if (d[i]) k = i;
      found = 1'b0; nib = '0;
      for (int i = 0; i < 16; i++) if (seg_tab[i] == s) begin found = 1'b1; nib = 4'(i); end
      exp_upd = 1'b1;
      if (found) begin
        exp_value[4*k +: 4] = nib;
        exp_valid[k] = 1'b1;
      end else begin
        exp_valid[k] = 1'b0;
        exp_bad = (s != 7'h00);
      end
    end
  endtask

  task automatic compare_outputs();
    check("value_out",   32'(value_out),   32'(exp_value));
    check("digit_valid", 32'(digit_valid), 32'(exp_valid));
    check("upd_pulse",   32'(upd_pulse),   32'(exp_upd));
    check("bad_pat",     32'(bad_pat),     32'(exp_bad));
    check("err_multi",   32'(err_multi),   32'(exp_err));
  endtask

  // One clock of logical stimulus; entered and left at the falling edge.
  task automatic cyc(input logic [3:0] d, input logic [6:0] s);
    logic [10:0] smp;
`ifdef SEG7_ACTIVE_LOW_EN
    dig_en = ~d; seg_in = ~s;
`else
    dig_en = d;  seg_in = s;
`endif
    @(posedge clk);
    smp = pipe2; pipe2 = pipe1; pipe1 = {dig_en, seg_in};
`ifdef SEG7_ACTIVE_LOW_EN
    smp = ~smp;
`endif
    model_step(smp[10:7], smp[6:0]);
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("rst_value",  32'(value_out),   32'h0);
    check("rst_valid",  32'(digit_valid), 32'h0);
    check("rst_upd",    32'(upd_pulse),   32'h0);
    check("rst_bad",    32'(bad_pat),     32'h0);
    check("rst_err",    32'(err_multi),   32'h0);
    model_reset();
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first, cnt, cnt2, len, r;
    logic [3:0] d;
    logic [6:0] s;
    logic [6:0] tog [5];
    logic [6:0] scan [4];
    model_reset();
    @(negedge clk);
    apply_reset(2);

    // Single digit held: capture lands on the 5th clock, exactly once.
    first = 0; cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(4'b0001, 7'h06);
      if (upd_pulse) begin cnt++; if (first == 0) first = i; end
    end
    check("t1_latency", 32'(first), 32'd5);
    check("t1_pulses",  32'(cnt),   32'd1);
    check("t1_nibble",  32'(value_out[3:0]), 32'h1);

    // Four-digit scan.
    scan = '{7'h3F, 7'h5B, 7'h4F, 7'h66};
    cnt = 0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) begin
        cyc(4'(1 << k), scan[k]);
        if (upd_pulse) cnt++;
      end
    check("t2_value",  32'(value_out),   32'h4320);
    check("t2_valid",  32'(digit_valid), 32'hF);
    check("t2_pulses", 32'(cnt),         32'd4);

    // Toggling pattern never settles; then a steady 9.
    tog = '{7'h7F, 7'h6F, 7'h7F, 7'h6F, 7'h7F};
    cnt = 0;
    for (int j = 0; j < 5; j++)
      for (int i = 0; i < 2; i++) begin
        cyc(4'b0010, tog[j]);
        if (upd_pulse) cnt++;
      end
    check("t3_nocap", 32'(cnt), 32'd0);
    for (int i = 0; i < 4; i++) cyc(4'b0010, 7'h6F);
    check("t3_early", 32'(value_out[7:4]), 32'h2);
    cyc(4'b0010, 7'h6F);
    check("t3_nine",  32'(value_out[7:4]), 32'h9);

    // Unknown pattern, then blank.
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0100, 7'h12);
      if (bad_pat) cnt++;
    end
    check("t4_bad",   32'(cnt), 32'd1);
    check("t4_valid", 32'(digit_valid[2]), 32'h0);
    check("t4_kept",  32'(value_out[11:8]), 32'h3);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0100, 7'h00);
      if (upd_pulse) cnt++;
      if (bad_pat) cnt2++;
    end
    check("t4_blank_upd", 32'(cnt),  32'd1);
    check("t4_blank_bad", 32'(cnt2), 32'd0);

    // Multi-hot strobes.
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0011, 7'h06);
      if (err_multi) cnt++;
      if (upd_pulse) cnt2++;
    end
    check("t5_err",   32'(cnt),  32'd1);
    check("t5_noupd", 32'(cnt2), 32'd0);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 7'h00);

    // Reset while a sample is settling.
    for (int i = 0; i < 3; i++) cyc(4'b1000, 7'h79);
    apply_reset(2);

    // Randomized scan traffic.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      d = 4'(1 << $urandom_range(0, 3));
      if (r < 8) d = 4'b0000;
      else if (r < 16) begin
        do d = 4'($urandom); while ($countones(d) < 2);
      end
      r = int'($urandom_range(0, 99));
      s = seg_tab[$urandom_range(0, 15)];
      if (r < 10) s = 7'h00;
      else if (r < 25) s = 7'($urandom);
      len = int'($urandom_range(1, 6));
      for (int c = 0; c < len; c++) cyc(d, s);
      if ($urandom_range(0, 49) == 0) apply_reset(2);
    end

    apply_reset(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
